// File: rtl/cpu6502_pkg.sv
// Shared 6502 status-stage definitions: flag instruction encodings, P bit positions, reset value.
package cpu6502_pkg;

  typedef enum logic [2:0] {
    FLAG_NONE = 3'b000,
    FLAG_CLC  = 3'b001,
    FLAG_SEC  = 3'b010,
    FLAG_CLI  = 3'b011,
    FLAG_SEI  = 3'b100,
    FLAG_CLD  = 3'b101,
    FLAG_SED  = 3'b110,
    FLAG_CLV  = 3'b111
  } flag_op_e;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam logic [7:0] P_RESET_VAL = 8'h34;

endpackage

// File: rtl/alu_status_stage_if.sv
// Bundle between the ALU/sequencer (master) and the status stage (slave).
interface alu_status_stage_if;
  logic       RDY;
  logic       alu_en;
  logic [7:0] alu_out;
  logic       alu_co;
  logic       alu_v;
  logic       alu_z;
  logic       alu_n;
  logic       alu_hc;
  logic       bcd_adj;
  logic       sub;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic       upd_bit;
  logic [2:0] flag_op;
  logic       load_p;
  logic       irq_entry;
  logic [7:0] db;
  logic [7:0] adj_out;
  logic       adj_valid;
  logic [7:0] p_out;
  logic [7:0] p_irq;
  logic       d_flag;

  modport master (
    output RDY, alu_en, alu_out, alu_co, alu_v, alu_z, alu_n, alu_hc,
           bcd_adj, sub, upd_nz, upd_c, upd_v, upd_bit, flag_op,
           load_p, irq_entry, db,
    input  adj_out, adj_valid, p_out, p_irq, d_flag
  );

  modport slave (
    input  RDY, alu_en, alu_out, alu_co, alu_v, alu_z, alu_n, alu_hc,
           bcd_adj, sub, upd_nz, upd_c, upd_v, upd_bit, flag_op,
           load_p, irq_entry, db,
    output adj_out, adj_valid, p_out, p_irq, d_flag
  );
endinterface

// File: rtl/bcd_adjust.sv
// Combinational decimal adjust of the binary ALU result; nibbles wrap independently.
module bcd_adjust (
  input  logic [7:0] alu_out,
  input  logic       hc,
  input  logic       co,
  input  logic       sub,
  input  logic       bcd_adj,
  output logic [7:0] result
);

  logic [3:0] lo_add;
  logic [3:0] hi_add;

  always_comb begin
    lo_add = 4'h0;
    hi_add = 4'h0;
    if (bcd_adj) begin
      // Add corrects on carry-out; subtract corrects on borrow (carry clear).
      if (sub) begin
        lo_add = hc ? 4'h0 : 4'hA;
        hi_add = co ? 4'h0 : 4'hA;
      end else begin
        lo_add = hc ? 4'h6 : 4'h0;
        hi_add = co ? 4'h6 : 4'h0;
      end
    end
    result = {alu_out[7:4] + hi_add, alu_out[3:0] + lo_add};
  end

endmodule

// File: rtl/alu_status_stage.sv
// 6502 ALU back end: registered decimal-adjusted result and the processor status register P.
// Define STATUS_CMOS_EN for 65C02 flag rules (N/Z from adjusted result, D cleared on interrupt entry).
module alu_status_stage
  import cpu6502_pkg::*;
#(
  parameter logic [7:0] P_RESET = P_RESET_VAL
) (
  input logic          clk,
  input logic          reset,
  alu_status_stage_if.slave bus
);

  logic [7:0] adj_byte;
  logic [7:0] adj_q;
  logic       valid_q;
  logic       n_q, v_q, d_q, i_q, z_q, c_q;
  logic       n_d, v_d, d_d, i_d, z_d, c_d;
  logic       res_n, res_z;

  bcd_adjust u_bcd_adjust (
    .alu_out (bus.alu_out),
    .hc      (bus.alu_hc),
    .co      (bus.alu_co),
    .sub     (bus.sub),
    .bcd_adj (bus.bcd_adj),
    .result  (adj_byte)
  );

`ifdef STATUS_CMOS_EN
  assign res_n = adj_byte[7];
  assign res_z = (adj_byte == 8'h00);
`else
  assign res_n = bus.alu_n;
  assign res_z = bus.alu_z;
`endif

  // Sources applied lowest priority first so later ones override per bit.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;

    if (bus.alu_en) begin
      if (bus.upd_nz) begin
        n_d = res_n;
        z_d = res_z;
      end
      if (bus.upd_v) v_d = bus.alu_v;
      if (bus.upd_c) c_d = bus.alu_co;
    end
    if (bus.upd_bit) begin
      n_d = bus.db[7];
      v_d = bus.db[6];
      z_d = bus.alu_z;
    end

    case (flag_op_e'(bus.flag_op))
      FLAG_CLC: c_d = 1'b0;
      FLAG_SEC: c_d = 1'b1;
      FLAG_CLI: i_d = 1'b0;
      FLAG_SEI: i_d = 1'b1;
      FLAG_CLD: d_d = 1'b0;
      FLAG_SED: d_d = 1'b1;
      FLAG_CLV: v_d = 1'b0;
      default:  ;
    endcase

    if (bus.irq_entry) begin
      i_d = 1'b1;
`ifdef STATUS_CMOS_EN
      d_d = 1'b0;
`endif
    end

    if (bus.load_p) begin
      n_d = bus.db[P_N];
      v_d = bus.db[P_V];
      d_d = bus.db[P_D];
      i_d = bus.db[P_I];
      z_d = bus.db[P_Z];
      c_d = bus.db[P_C];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adj_q   <= 8'h00;
      valid_q <= 1'b0;
      n_q     <= P_RESET[P_N];
      v_q     <= P_RESET[P_V];
      d_q     <= P_RESET[P_D];
      i_q     <= P_RESET[P_I];
      z_q     <= P_RESET[P_Z];
      c_q     <= P_RESET[P_C];
    end else if (!bus.RDY) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.alu_en;
      if (bus.alu_en) adj_q <= adj_byte;
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  assign bus.adj_out   = adj_q;
  assign bus.adj_valid = valid_q;
  assign bus.p_out     = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  assign bus.p_irq     = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
  assign bus.d_flag    = d_q;

endmodule

// File: tb/tb_alu_status_stage.sv
// Directed-vector bench for alu_status_stage; expectations follow STATUS_CMOS_EN when defined.
module tb_alu_status_stage;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  alu_status_stage_if bus ();

  alu_status_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef STATUS_CMOS_EN
  localparam logic [7:0] EXP_P_AFTER_WRAP = 8'h37;
  localparam logic [7:0] EXP_P_IRQ_D      = 8'hB5;
`else
  localparam logic [7:0] EXP_P_AFTER_WRAP = 8'hB5;
  localparam logic [7:0] EXP_P_IRQ_D      = 8'hBD;
`endif

  task automatic idle_inputs();
    bus.RDY       = 1'b1;
    bus.alu_en    = 1'b0;
    bus.alu_out   = 8'h00;
    bus.alu_co    = 1'b0;
    bus.alu_v     = 1'b0;
    bus.alu_z     = 1'b0;
    bus.alu_n     = 1'b0;
    bus.alu_hc    = 1'b0;
    bus.bcd_adj   = 1'b0;
    bus.sub       = 1'b0;
    bus.upd_nz    = 1'b0;
    bus.upd_c     = 1'b0;
    bus.upd_v     = 1'b0;
    bus.upd_bit   = 1'b0;
    bus.flag_op   = 3'b000;
    bus.load_p    = 1'b0;
    bus.irq_entry = 1'b0;
    bus.db        = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    vectors++;
    if (bus.p_out !== 8'h34) begin
      $display("FAIL reset_p_out got %h exp 34", bus.p_out); miscompares++;
    end
    vectors++;
    if (bus.p_irq !== 8'h24) begin
      $display("FAIL reset_p_irq got %h exp 24", bus.p_irq); miscompares++;
    end
    vectors++;
    if (bus.adj_out !== 8'h00 || bus.adj_valid !== 1'b0) begin
      $display("FAIL reset_adj got %h/%b exp 00/0", bus.adj_out, bus.adj_valid); miscompares++;
    end
    reset = 1'b0;
  endtask

  task automatic test_bcd_add();
    bus.alu_en = 1'b1; bus.alu_out = 8'h1A; bus.alu_hc = 1'b1; bus.alu_co = 1'b0;
    bus.bcd_adj = 1'b1; bus.upd_c = 1'b1; bus.upd_nz = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (bus.adj_out !== 8'h10 || bus.adj_valid !== 1'b1 || bus.p_out[0] !== 1'b0) begin
      $display("FAIL bcd_add got adj=%h v=%b c=%b exp 10/1/0", bus.adj_out, bus.adj_valid, bus.p_out[0]);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus.adj_valid !== 1'b0 || bus.adj_out !== 8'h10) begin
      $display("FAIL bcd_add_pulse got adj=%h v=%b exp 10/0", bus.adj_out, bus.adj_valid); miscompares++;
    end
  endtask

  task automatic test_bcd_sub();
    bus.alu_en = 1'b1; bus.alu_out = 8'h0F; bus.alu_hc = 1'b0; bus.alu_co = 1'b1;
    bus.sub = 1'b1; bus.bcd_adj = 1'b1; bus.upd_c = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (bus.adj_out !== 8'h09 || bus.p_out[0] !== 1'b1) begin
      $display("FAIL bcd_sub got adj=%h c=%b exp 09/1", bus.adj_out, bus.p_out[0]); miscompares++;
    end
  endtask

  task automatic test_bcd_wrap();
    bus.alu_en = 1'b1; bus.alu_out = 8'hAA; bus.alu_hc = 1'b1; bus.alu_co = 1'b1;
    bus.alu_n = 1'b1; bus.alu_z = 1'b0; bus.bcd_adj = 1'b1; bus.upd_c = 1'b1; bus.upd_nz = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (bus.adj_out !== 8'h00) begin
      $display("FAIL bcd_wrap_adj got %h exp 00", bus.adj_out); miscompares++;
    end
    vectors++;
    if (bus.p_out !== EXP_P_AFTER_WRAP) begin
      $display("FAIL bcd_wrap_p got %h exp %h", bus.p_out, EXP_P_AFTER_WRAP); miscompares++;
    end
  endtask

  task automatic test_passthrough();
    bus.alu_en = 1'b1; bus.alu_out = 8'h3C; bus.alu_hc = 1'b1; bus.alu_co = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (bus.adj_out !== 8'h3C || bus.adj_valid !== 1'b1) begin
      $display("FAIL passthrough got %h/%b exp 3C/1", bus.adj_out, bus.adj_valid); miscompares++;
    end
  endtask

  task automatic test_rdy_stall();
    bus.RDY = 1'b0; bus.load_p = 1'b1; bus.db = 8'hFF; bus.alu_en = 1'b1; bus.alu_out = 8'h55;
    tick();
    vectors++;
    if (bus.p_out !== EXP_P_AFTER_WRAP) begin
      $display("FAIL stall_p got %h exp %h", bus.p_out, EXP_P_AFTER_WRAP); miscompares++;
    end
    vectors++;
    if (bus.adj_valid !== 1'b0 || bus.adj_out !== 8'h3C) begin
      $display("FAIL stall_adj got %h/%b exp 3C/0", bus.adj_out, bus.adj_valid); miscompares++;
    end
    idle_inputs();
    bus.load_p = 1'b1; bus.db = 8'hFF;
    tick();
    idle_inputs();
    vectors++;
    if (bus.p_out !== 8'hFF || bus.p_irq !== 8'hEF || bus.d_flag !== 1'b1) begin
      $display("FAIL load_p got %h/%h/%b exp FF/EF/1", bus.p_out, bus.p_irq, bus.d_flag); miscompares++;
    end
  endtask

  task automatic test_priority();
    bus.flag_op = 3'b110; bus.alu_en = 1'b1; bus.upd_nz = 1'b1;
    bus.alu_out = 8'h80; bus.alu_n = 1'b1; bus.alu_z = 1'b0;
    tick();
    idle_inputs();
    vectors++;
    if (bus.p_out !== 8'hFD) begin
      $display("FAIL sed_nz got %h exp FD", bus.p_out); miscompares++;
    end
    bus.load_p = 1'b1; bus.db = 8'h00; bus.irq_entry = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (bus.p_out !== 8'h30 || bus.p_irq !== 8'h20) begin
      $display("FAIL load_over_irq got %h/%h exp 30/20", bus.p_out, bus.p_irq); miscompares++;
    end
  endtask

  task automatic test_flag_ops();
    logic [2:0] ops [8];
    logic [7:0] dbs [8];
    logic [7:0] exps [8];
    ops  = '{3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b000, 3'b111};
    dbs  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h00};
    exps = '{8'h31, 8'h35, 8'h3D, 8'h3C, 8'h38, 8'h30, 8'hF0, 8'hB0};
    for (int k = 0; k < 8; k++) begin
      bus.flag_op = ops[k];
      if (k == 6) begin bus.load_p = 1'b1; bus.db = dbs[k]; end
      tick();
      idle_inputs();
      vectors++;
      if (bus.p_out !== exps[k]) begin
        $display("FAIL flag_op_%0d got %h exp %h", k, bus.p_out, exps[k]); miscompares++;
      end
    end
  endtask

  task automatic test_irq_entry();
    bus.irq_entry = 1'b1; bus.alu_en = 1'b1; bus.upd_c = 1'b1; bus.alu_co = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (bus.p_out !== 8'hB5) begin
      $display("FAIL irq_with_c got %h exp B5", bus.p_out); miscompares++;
    end
    bus.flag_op = 3'b110;
    tick();
    idle_inputs();
    bus.irq_entry = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (bus.p_out !== EXP_P_IRQ_D) begin
      $display("FAIL irq_d got %h exp %h", bus.p_out, EXP_P_IRQ_D); miscompares++;
    end
  endtask

  task automatic test_bit_and_gating();
    bus.load_p = 1'b1; bus.db = 8'h00;
    tick();
    idle_inputs();
    bus.upd_bit = 1'b1; bus.upd_nz = 1'b1; bus.alu_en = 1'b1; bus.db = 8'h40;
    bus.alu_out = 8'h80; bus.alu_n = 1'b1; bus.alu_z = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (bus.p_out !== 8'h72) begin
      $display("FAIL bit_over_nz got %h exp 72", bus.p_out); miscompares++;
    end
    bus.upd_c = 1'b1; bus.upd_nz = 1'b1; bus.upd_v = 1'b1;
    bus.alu_co = 1'b1; bus.alu_v = 1'b0; bus.alu_n = 1'b1; bus.alu_z = 1'b0;
    tick();
    idle_inputs();
    vectors++;
    if (bus.p_out !== 8'h72 || bus.adj_valid !== 1'b0) begin
      $display("FAIL upd_no_en got %h/%b exp 72/0", bus.p_out, bus.adj_valid); miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    bus.alu_en = 1'b1; bus.alu_out = 8'h1A; bus.alu_hc = 1'b1; bus.bcd_adj = 1'b1;
    tick();
    vectors++;
    if (bus.adj_out !== 8'h10 || bus.adj_valid !== 1'b1) begin
      $display("FAIL b2b_first got %h/%b exp 10/1", bus.adj_out, bus.adj_valid); miscompares++;
    end
    bus.alu_out = 8'h0F; bus.alu_hc = 1'b0; bus.alu_co = 1'b1; bus.sub = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (bus.adj_out !== 8'h09 || bus.adj_valid !== 1'b1) begin
      $display("FAIL b2b_second got %h/%b exp 09/1", bus.adj_out, bus.adj_valid); miscompares++;
    end
    tick();
    vectors++;
    if (bus.adj_valid !== 1'b0) begin
      $display("FAIL b2b_end got %b exp 0", bus.adj_valid); miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle_inputs();
    test_reset();
    test_bcd_add();
    test_bcd_sub();
    test_bcd_wrap();
    test_passthrough();
    test_rdy_stall();
    test_priority();
    test_flag_ops();
    test_irq_entry();
    test_bit_and_gating();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
